regfile_mp: RTL and testbench

- Parametrised successor to the core's 32x32 integer register file, in the ID stage of the 5-stage RISC-V pipeline.
- Provides NRD combinational read ports and one posedge write port.
- Adds optional write-to-read bypass, hardwired x0, async clear of all registers, and a per-register pending scoreboard so ID can detect load-use and other RAW hazards without a separate table.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 63 ++++++
 rtl/regfile_mp.sv | 75 +++++++
 tb/tb_regfile_mp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned ZERO_REG = 0;

    // LSB of read port k's address field inside the packed rs_addr bus.
    function automatic int unsigned rd_addr_of(input int unsigned k, input int unsigned aw);
        return k * aw;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for RAW hazard detection in ID; x0 is never pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned AW     = $clog2(NREG),
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_pend,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic              pend_set,
    input  logic [AW-1:0]     pend_addr,
    input  logic              flush
);

    logic [NREG-1:1] pend_q;
    logic [NREG-1:1] pend_d;
    logic [NREG-1:0] pend_full;

    // Flush beats everything; a new producer's set beats an older producer's writeback.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (pend_set && pend_addr == AW'(r)) begin
                    pend_d[r] = 1'b1;
                end else if (we && wa == AW'(r)) begin
                    pend_d[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_full = {pend_q, 1'b0};

    for (genvar k = 0; k < NRD; k++) begin : g_pend
        logic [AW-1:0] a;
        logic          byp_hit;
        logic          in_range;

        assign a        = rs_addr[rd_addr_of(k, AW) +: AW];
        assign byp_hit  = (BYPASS != 0) && we && (wa == a);
        assign in_range = 32'(a) < NREG;
        assign rs_pend[k] = rst_n && in_range && (a != AW'(ZERO_REG)) && !byp_hit
                            && pend_full[a];
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file with hardwired x0, optional
// write-to-read bypass and an integrated pending scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned AW     = $clog2(NREG),
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_pend,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                pend_set,
    input  logic [AW-1:0]       pend_addr,
    input  logic                flush
);

    logic [XLEN-1:0] rf_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we && wa != AW'(ZERO_REG)) begin
            rf_q[wa] <= wd;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic            byp_hit;
        logic [XLEN-1:0] rd;

        assign a = rs_addr[rd_addr_of(k, AW) +: AW];
        // Bypass is gated by rst_n so a held reset reads zero even while we is high.
        assign byp_hit = rst_n && (BYPASS != 0) && we && (wa == a) && (a != AW'(ZERO_REG));

        always_comb begin
            rd = '0;
            if (byp_hit) begin
                rd = wd;
            end else if (a != AW'(ZERO_REG) && 32'(a) < NREG) begin
                rd = rf_q[a];
            end
        end

        assign rs_data[k*XLEN +: XLEN] = rd;
    end

    rf_scoreboard #(
        .NREG   (NREG),
        .AW     (AW),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rs_pend   (rs_pend),
        .we        (we),
        .wa        (wa),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .flush     (flush)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: the driver queues expected read results, a negedge monitor checks them
// against a bypassing and a non-bypassing instance.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [63:0] rs_data_nb;
    logic [1:0]  rs_pend;
    logic [1:0]  rs_pend_nb;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        flush;

    typedef struct {
        string       name;
        logic [63:0] data;
        logic [1:0]  pend;
        logic [63:0] data_nb;
        logic [1:0]  pend_nb;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_it;
    int   checks;
    int   failures;

    regfile_mp #(
        .XLEN   (32),
        .NREG   (32),
        .NRD    (2),
        .BYPASS (1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .rs_pend   (rs_pend),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .flush     (flush)
    );

    regfile_mp #(
        .XLEN   (32),
        .NREG   (32),
        .NRD    (2),
        .BYPASS (0)
    ) u_dut_nb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data_nb),
        .rs_pend   (rs_pend_nb),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are combinational, compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_it = exp_q.pop_front();
            checks++;
            if (rs_data !== mon_it.data) begin
                failures++;
                $display("FAIL %s bypass data: got %h want %h", mon_it.name, rs_data, mon_it.data);
            end
            checks++;
            if (rs_pend !== mon_it.pend) begin
                failures++;
                $display("FAIL %s bypass pend: got %b want %b", mon_it.name, rs_pend, mon_it.pend);
            end
            checks++;
            if (rs_data_nb !== mon_it.data_nb) begin
                failures++;
                $display("FAIL %s nobypass data: got %h want %h", mon_it.name, rs_data_nb,
                         mon_it.data_nb);
            end
            checks++;
            if (rs_pend_nb !== mon_it.pend_nb) begin
                failures++;
                $display("FAIL %s nobypass pend: got %b want %b", mon_it.name, rs_pend_nb,
                         mon_it.pend_nb);
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic cyc(input logic we_v, input logic [4:0] wa_v, input logic [31:0] wd_v,
                       input logic ps_v, input logic [4:0] pa_v, input logic fl_v,
                       input logic [4:0] r0, input logic [4:0] r1);
        @(posedge clk);
        #1;
        we        = we_v;
        wa        = wa_v;
        wd        = wd_v;
        pend_set  = ps_v;
        pend_addr = pa_v;
        flush     = fl_v;
        rs_addr   = {r1, r0};
    endtask

    task automatic expect2(input string name, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] p, input logic [31:0] nd0,
                           input logic [31:0] nd1, input logic [1:0] np);
        exp_t e;
        e.name    = name;
        e.data    = {d1, d0};
        e.pend    = p;
        e.data_nb = {nd1, nd0};
        e.pend_nb = np;
        exp_q.push_back(e);
    endtask

    task automatic expect_same(input string name, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] p);
        expect2(name, d0, d1, p, d0, d1, p);
    endtask

    initial begin
        int waited;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        pend_set  = 1'b0;
        pend_addr = '0;
        flush     = 1'b0;
        rs_addr   = {5'd0, 5'd5};
        #1;
        expect_same("reset_state", 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Write x5, mark it pending, then pull reset asynchronously mid-cycle.
        cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd5, 5'd5);
        expect2("wr_x5", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0, 32'h0, 2'b00);
        cyc(0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd5, 5'd5);
        expect_same("rd_x5_set", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd5, 5'd5);
        expect_same("x5_pend", 32'hDEADBEEF, 32'hDEADBEEF, 2'b11);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        we      = 1'b1;
        wa      = 5'd5;
        wd      = 32'h11;
        rs_addr = {5'd0, 5'd5};
        expect_same("async_reset", 32'h0, 32'h0, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        we    = 1'b0;
        rs_addr = {5'd5, 5'd5};
        expect_same("after_reset", 32'h0, 32'h0, 2'b00);

        // x0 is hardwired.
        cyc(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 0, 5'd0, 5'd0);
        expect_same("x0_write", 32'h0, 32'h0, 2'b00);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 5'd0);
        expect_same("x0_later", 32'h0, 32'h0, 2'b00);

        // Bypass versus next-cycle visibility.
        cyc(1, 5'd7, 32'hAAAA0000, 0, 5'd0, 0, 5'd7, 5'd7);
        expect2("x7_first", 32'hAAAA0000, 32'hAAAA0000, 2'b00, 32'h0, 32'h0, 2'b00);
        cyc(1, 5'd7, 32'h12345678, 0, 5'd0, 0, 5'd7, 5'd7);
        expect2("x7_bypass", 32'h12345678, 32'h12345678, 2'b00,
                32'hAAAA0000, 32'hAAAA0000, 2'b00);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd7, 5'd7);
        expect_same("x7_next", 32'h12345678, 32'h12345678, 2'b00);

        // Scoreboard set, hold, and clear by writeback.
        cyc(0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3, 5'd0);
        expect_same("x3_set_c0", 32'h0, 32'h0, 2'b00);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd3, 5'd3);
        expect_same("x3_pend_c1", 32'h0, 32'h0, 2'b11);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd3, 5'd3);
        expect_same("x3_pend_c2", 32'h0, 32'h0, 2'b11);
        cyc(1, 5'd3, 32'h42, 0, 5'd0, 0, 5'd3, 5'd3);
        expect2("x3_wb_c3", 32'h42, 32'h42, 2'b00, 32'h0, 32'h0, 2'b11);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd3, 5'd3);
        expect_same("x3_clear_c4", 32'h42, 32'h42, 2'b00);

        // Set and clear on the same register: set wins.
        cyc(1, 5'd9, 32'h99, 1, 5'd9, 0, 5'd9, 5'd9);
        expect2("x9_set_wr", 32'h99, 32'h99, 2'b00, 32'h0, 32'h0, 2'b00);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd9, 5'd9);
        expect_same("x9_after", 32'h99, 32'h99, 2'b11);

        // Set and clear on different registers: both apply.
        cyc(0, 5'd0, 32'h0, 1, 5'd6, 0, 5'd6, 5'd4);
        expect_same("x6_set", 32'h0, 32'h0, 2'b00);
        cyc(1, 5'd6, 32'h66, 1, 5'd4, 0, 5'd6, 5'd4);
        expect2("x4set_x6wr", 32'h66, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd6, 5'd4);
        expect_same("x4_x6_after", 32'h66, 32'h0, 2'b10);

        // Flush drops all pending bits, including a concurrent set.
        cyc(0, 5'd0, 32'h0, 1, 5'd1, 0, 5'd1, 5'd2);
        expect_same("set_x1", 32'h0, 32'h0, 2'b00);
        cyc(0, 5'd0, 32'h0, 1, 5'd2, 0, 5'd1, 5'd2);
        expect_same("set_x2", 32'h0, 32'h0, 2'b01);
        cyc(0, 5'd0, 32'h0, 1, 5'd31, 0, 5'd1, 5'd2);
        expect_same("set_x31", 32'h0, 32'h0, 2'b11);
        cyc(0, 5'd0, 32'h0, 1, 5'd10, 1, 5'd31, 5'd10);
        expect_same("flush_cyc", 32'h0, 32'h0, 2'b01);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd31, 5'd10);
        expect_same("flush_x31_x10", 32'h0, 32'h0, 2'b00);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd1, 5'd2);
        expect_same("flush_x1_x2", 32'h0, 32'h0, 2'b00);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd7, 5'd3);
        expect_same("flush_data_kept", 32'h12345678, 32'h42, 2'b00);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd9, 5'd4);
        expect_same("flush_x9_x4", 32'h99, 32'h0, 2'b00);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
